// File: rtl/norm_fp.sv
// norm_fp: renormalizes a 64-bit fixed-point fraction in [0,1) into an IEEE-754 double.
// Three stages: capture, leading-zero normalize, round-to-nearest-even and pack.
module norm_fp #(
    parameter int FPW  = 63,
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pushin,
    input  logic            signin,
    input  logic [SIZE:0]   fract_lt,
    input  logic [FPW:0]    delta_denorm,
    output logic            pushout,
    output logic [63:0]     dout
);
    localparam int W  = FPW + 1;
    localparam int ZW = $clog2(W + 1);
    logic          v1, v2, v3;
    logic          s1, s2;
    logic [W-1:0]  f, f_in, sh;
    logic [W-2:0]  n;
    logic [ZW-1:0] z, z_q;
    logic          zf;
    logic [51:0]   mant, m;
    logic          g, st, up, c;
    logic [10:0]   e;
    logic          unused;

    assign f_in   = {fract_lt, delta_denorm[FPW-SIZE-1:0]};
    // The normalized MSB is implicit in the double, so it is never stored.
    assign unused = ^{delta_denorm[FPW:FPW-SIZE], sh[W-1]};

    always_comb begin
        z = ZW'(W);
        for (int i = 0; i < W; i++)
            if (f[i]) z = ZW'(W - 1 - i);
    end

    assign sh   = f << z;
    assign mant = n[W-2 -: 52];
    assign g    = n[W-54];
    assign st   = |n[W-55:0];
    assign up   = g & (st | mant[0]);
    // A rounding carry wraps m to zero and bumps the exponent by one.
    assign {c, m} = {1'b0, mant} + 53'(up);
    assign e      = 11'd1022 - 11'(z_q) + 11'(c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            f    <= '0;
            s1   <= 1'b0;
            n    <= '0;
            z_q  <= '0;
            zf   <= 1'b0;
            s2   <= 1'b0;
            dout <= '0;
        end else begin
            v1 <= pushin;
            v2 <= v1;
            v3 <= v2;
            if (pushin) begin
                f  <= f_in;
                s1 <= signin;
            end
            if (v1) begin
                n   <= sh[W-2:0];
                z_q <= z;
                zf  <= (f == '0);
                s2  <= s1;
            end
            if (v2) dout <= zf ? {s2, 63'b0} : {s2, e, m};
        end
    end

    assign pushout = v3;
endmodule

// File: tb/tb_norm_fp.sv
// tb_norm_fp: directed and random checks of norm_fp against a queue of expected doubles.
module tb_norm_fp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pushin = 1'b0;
    logic        signin = 1'b0;
    logic [8:0]  fract_lt = '0;
    logic [63:0] delta_denorm = '0;
    logic        pushout;
    logic [63:0] dout;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] q[$];
    logic [2:0]  vm = '0;
    logic [63:0] last = '0;
    int          lat;

    always #5 clk = ~clk;

    norm_fp dut (
        .clk(clk), .rst(rst), .pushin(pushin), .signin(signin),
        .fract_lt(fract_lt), .delta_denorm(delta_denorm),
        .pushout(pushout), .dout(dout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic sg, input logic [63:0] f, input logic [63:0] exp);
        @(negedge clk);
        pushin       = 1'b1;
        signin       = sg;
        fract_lt     = f[63:55];
        delta_denorm = {9'($urandom), f[54:0]};
        q.push_back(exp);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            pushin       = 1'b0;
            signin       = 1'($urandom);
            fract_lt     = 9'($urandom);
            delta_denorm = {$urandom, $urandom};
        end
    endtask

    // Random double with exponent 991..1022, trimmed so it fits the 64-bit fraction exactly.
    function automatic void gen(output logic sg, output logic [63:0] f, output logic [63:0] exp);
        int          e, sh;
        logic [51:0] m;
        logic [52:0] sig;
        e  = int'($urandom_range(991, 1022));
        m  = 52'({$urandom, $urandom});
        sg = 1'($urandom);
        sh = e - 1011;
        if (sh < 0) m = m & ~((52'd1 << (-sh)) - 52'd1);
        sig = {1'b1, m};
        f   = (sh >= 0) ? (64'(sig) << sh) : (64'(sig) >> (-sh));
        exp = {sg, 11'(e), m};
    endfunction

    task automatic measure_latency();
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #2;
            if (i == 1) pushin = 1'b0;
            if (pushout && lat == 0) lat = i;
        end
        check("latency", 64'(lat), 64'd3);
    endtask

    always @(posedge clk) begin
        vm = rst ? {vm[1:0], pushin} : 3'b0;
        if (!rst) last = '0;
        #1;
        if (rst) begin
            check("pushout", {63'b0, pushout}, {63'b0, vm[2]});
            if (pushout) begin
                if (q.size() == 0) check("sb_underflow", 64'(q.size()), 64'd1);
                else begin
                    last = q.pop_front();
                    check("dout", dout, last);
                end
            end else check("hold", dout, last);
        end
    end

    initial begin
        logic        sg;
        logic [63:0] f, exp;
        repeat (4) begin
            @(negedge clk);
            pushin   = 1'b1;
            fract_lt = 9'($urandom);
            check("rst_pushout", {63'b0, pushout}, 64'd0);
            check("rst_dout", dout, 64'd0);
        end
        @(negedge clk);
        pushin = 1'b0;
        rst    = 1'b1;
        drive(1'b0, 64'h8000000000000000, 64'h3FE0000000000000);
        measure_latency();
        idle(2);
        drive(1'b0, 64'h8000000000000000, 64'h3FE0000000000000);
        drive(1'b1, 64'h8000000000000000, 64'hBFE0000000000000);
        drive(1'b0, 64'h3000000000000000, 64'h3FC8000000000000);
        drive(1'b0, 64'h0, 64'h0);
        drive(1'b1, 64'h0, 64'h8000000000000000);
        drive(1'b0, 64'h1, 64'h3BF0000000000000);
        idle(2);
        drive(1'b0, 64'h8000000000000400, 64'h3FE0000000000000);
        drive(1'b0, 64'h8000000000000C00, 64'h3FE0000000000002);
        drive(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h3FF0000000000000);
        idle(4);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            gen(sg, f, exp);
            drive(sg, f, exp);
        end
        idle(6);
        for (int i = 0; i < 3; i++) begin
            gen(sg, f, exp);
            drive(sg, f, exp);
        end
        @(negedge clk);
        pushin = 1'b0;
        rst    = 1'b0;
        #1;
        check("midrst_pushout", {63'b0, pushout}, 64'd0);
        check("midrst_dout", dout, 64'd0);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_pushout", {63'b0, pushout}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        drive(1'b1, 64'h3000000000000000, 64'hBFC8000000000000);
        measure_latency();
        idle(4);
        check("sb_drain", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
